// File: rtl/dmem_arb_pkg.sv
// Shared types and default address-map constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {M0 = 2'd0, M1 = 2'd1, NONE = 2'd2} master_e;

  typedef enum logic [1:0] {TGT_DMEM = 2'd0, TGT_MMIO = 2'd1, TGT_ERR = 2'd2} target_e;

  localparam logic [31:0] DEF_MMIO_BASE = 32'h0200_0000;
  localparam logic [31:0] DEF_MMIO_MASK = 32'hFFFF_FF00;

endpackage

// File: rtl/dmem_arb_decode.sv
// Address decode: byte address -> dmem, MMIO window or decode error.
module dmem_arb_decode
  import dmem_arb_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE  = ADDR_W'(DEF_MMIO_BASE),
  parameter logic [ADDR_W-1:0] MMIO_MASK  = ADDR_W'(DEF_MMIO_MASK),
  parameter int                DMEM_WORDS = 64
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [1:0]        tgt
);

  localparam logic [ADDR_W-1:0] DMEM_LIMIT = ADDR_W'(4 * DMEM_WORDS);

  // MMIO takes priority so the window stays reachable even if it overlaps dmem.
  always_comb begin
    if ((addr & MMIO_MASK) == MMIO_BASE) tgt = TGT_MMIO;
    else if (addr < DMEM_LIMIT)          tgt = TGT_DMEM;
    else                                 tgt = TGT_ERR;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter with lock for the dmem port and MMIO window.
// Optional grant/conflict statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE  = ADDR_W'(DEF_MMIO_BASE),
  parameter logic [ADDR_W-1:0] MMIO_MASK  = ADDR_W'(DEF_MMIO_MASK),
  parameter int                DMEM_WORDS = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic                m0_lock,
  input  logic [DATA_W/8-1:0] m0_be,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic                m0_err,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic                m1_lock,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic                m1_err,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mmio_en,
  output logic                mmio_we,
  output logic [DATA_W/8-1:0] mmio_be,
  output logic [ADDR_W-1:0]   mmio_addr,
  output logic [DATA_W-1:0]   mmio_wdata,
  input  logic [DATA_W-1:0]   mmio_rdata,
  output logic                busy
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]         m0_gnt_cnt,
  output logic [15:0]         m1_gnt_cnt,
  output logic [15:0]         conflict_cnt
`endif
);

  master_e             rr_ptr, lock_owner, rr_next, lock_next, win;
  logic                vld_p0, we_p0, lock_p0;
  logic [DATA_W/8-1:0] be_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic [1:0]          tgt_p0;
  logic                vld_p1, we_p1;
  master_e             owner_p1;
  logic [1:0]          tgt_p1;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= M0;
      lock_owner <= NONE;
    end else begin
      rr_ptr     <= rr_next;
      lock_owner <= lock_next;
    end
  end

  always_comb begin
    rr_next   = rr_ptr;
    lock_next = lock_owner;
    if ((lock_owner == M0 && !m0_req) || (lock_owner == M1 && !m1_req)) lock_next = NONE;
    if (vld_p0) begin
      rr_next   = (win == M0) ? M1 : M0;
      lock_next = lock_p0 ? win : NONE;
    end
  end

  // Grant is held off while reset is asserted so every output reads 0.
  always_comb begin
    win = NONE;
    if (reset) begin
      if (lock_owner == M0 && m0_req)      win = M0;
      else if (lock_owner == M1 && m1_req) win = M1;
      else if (m0_req && m1_req)           win = rr_ptr;
      else if (m0_req)                     win = M0;
      else if (m1_req)                     win = M1;
    end
    vld_p0   = (win != NONE);
    m0_gnt   = (win == M0);
    m1_gnt   = (win == M1);
    we_p0    = m1_gnt ? m1_we    : m0_we;
    lock_p0  = m1_gnt ? m1_lock  : m0_lock;
    be_p0    = m1_gnt ? m1_be    : m0_be;
    addr_p0  = m1_gnt ? m1_addr  : m0_addr;
    wdata_p0 = m1_gnt ? m1_wdata : m0_wdata;

    mem_en     = vld_p0 && (tgt_p0 == TGT_DMEM);
    mem_we     = mem_en && we_p0;
    mem_be     = mem_en ? be_p0    : '0;
    mem_addr   = mem_en ? addr_p0  : '0;
    mem_wdata  = mem_en ? wdata_p0 : '0;
    mmio_en    = vld_p0 && (tgt_p0 == TGT_MMIO);
    mmio_we    = mmio_en && we_p0;
    mmio_be    = mmio_en ? be_p0    : '0;
    mmio_addr  = mmio_en ? addr_p0  : '0;
    mmio_wdata = mmio_en ? wdata_p0 : '0;
  end

  dmem_arb_decode #(
    .ADDR_W    (ADDR_W),
    .MMIO_BASE (MMIO_BASE),
    .MMIO_MASK (MMIO_MASK),
    .DMEM_WORDS(DMEM_WORDS)
  ) u_decode (
    .addr(addr_p0),
    .tgt (tgt_p0)
  );

  // p0 -> p1: issue cycle to response cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    owner_p1 <= win;
    we_p1    <= we_p0;
    tgt_p1   <= tgt_p0;
  end

  always_comb begin
    rsp_rdata = '0;
    if (vld_p1 && !we_p1) begin
      if (tgt_p1 == TGT_DMEM)      rsp_rdata = mem_rdata;
      else if (tgt_p1 == TGT_MMIO) rsp_rdata = mmio_rdata;
    end
    rsp_err   = vld_p1 && (tgt_p1 == TGT_ERR);
    m0_rvalid = vld_p1 && (owner_p1 == M0);
    m1_rvalid = vld_p1 && (owner_p1 == M1);
    m0_rdata  = m0_rvalid ? rsp_rdata : '0;
    m1_rdata  = m1_rvalid ? rsp_rdata : '0;
    m0_err    = m0_rvalid && rsp_err;
    m1_err    = m1_rvalid && rsp_err;
    busy      = vld_p1;
  end

`ifdef DMEM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_gnt_cnt   <= '0;
      m1_gnt_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (m0_gnt)           m0_gnt_cnt   <= sat_inc(m0_gnt_cnt);
      if (m1_gnt)           m1_gnt_cnt   <= sat_inc(m1_gnt_cnt);
      if (m0_req && m1_req) conflict_cnt <= sat_inc(conflict_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a response scoreboard and memory/MMIO stubs.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we, mmio_en, mmio_we, busy;
  logic [3:0]  mem_be, mmio_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, mmio_addr, mmio_wdata, mmio_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] m0_gnt_cnt, m1_gnt_cnt, conflict_cnt;
`endif

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mmio_en(mmio_en), .mmio_we(mmio_we), .mmio_be(mmio_be), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
    .busy(busy)
`ifdef DMEM_ARB_STATS_EN
    , .m0_gnt_cnt(m0_gnt_cnt), .m1_gnt_cnt(m1_gnt_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  // dmem and MMIO stubs: read data appears the cycle after the strobe
  logic        load;
  logic [31:0] dmem [0:63];
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 64; i++) dmem[i] <= (i == 4) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(i);
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) dmem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= dmem[mem_addr[7:2]];
      end
    end
    if (mmio_en) mmio_rdata <= 32'hA5A5_0000 | {24'h0, mmio_addr[7:0]};
  end

  typedef struct {
    logic pre_rst;
    logic r0, w0, l0; logic [31:0] a0, d0;
    logic r1, w1, l1; logic [31:0] a1, d1;
    logic g0, g1, men, mmen; logic [31:0] rd; logic err;
  } vec_t;

  typedef struct {
    logic vld; logic m1; logic [31:0] rd; logic err;
  } rsp_t;

  localparam int NV = 19;
  vec_t tbl [NV];
  rsp_t sbq [$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic vec_t mk(input logic pre, input logic r0, w0, l0, input logic [31:0] a0, d0,
                              input logic r1, w1, l1, input logic [31:0] a1, d1,
                              input logic g0, g1, men, mmen, input logic [31:0] rd, input logic err);
    vec_t v;
    v.pre_rst = pre;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.men = men; v.mmen = mmen; v.rd = rd; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_be = 4'hF; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_be = 4'hF; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic drive(input vec_t v);
    m0_req = v.r0; m0_we = v.w0; m0_lock = v.l0; m0_addr = v.a0; m0_wdata = v.d0; m0_be = 4'hF;
    m1_req = v.r1; m1_we = v.w1; m1_lock = v.l1; m1_addr = v.a1; m1_wdata = v.d1; m1_be = 4'hF;
  endtask

  task automatic do_reset();
    idle();
    m0_req = 1'b1;
    reset = 1'b0;
    sbq.delete();
    @(posedge clk); #1;
    check1("rst_m0_gnt", m0_gnt, 1'b0);
    check1("rst_mem_en", mem_en, 1'b0);
    check1("rst_m0_rvalid", m0_rvalid, 1'b0);
    check1("rst_m1_rvalid", m1_rvalid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    idle();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_resp();
    rsp_t e;
    e.vld = 1'b0; e.m1 = 1'b0; e.rd = '0; e.err = 1'b0;
    if (sbq.size() > 0) e = sbq.pop_front();
    check1("m0_rvalid", m0_rvalid, e.vld && !e.m1);
    check1("m1_rvalid", m1_rvalid, e.vld && e.m1);
    check1("busy", busy, e.vld);
    if (e.vld && e.m1) begin
      check("m1_rdata", m1_rdata, e.rd);
      check1("m1_err", m1_err, e.err);
      check("m0_rdata_idle", m0_rdata, 32'h0);
    end else if (e.vld) begin
      check("m0_rdata", m0_rdata, e.rd);
      check1("m0_err", m0_err, e.err);
      check("m1_rdata_idle", m1_rdata, 32'h0);
    end
  endtask

  task automatic check_issue(input vec_t v);
    rsp_t        r;
    logic [31:0] wa, wd;
    logic        ww;
    check1("m0_gnt", m0_gnt, v.g0);
    check1("m1_gnt", m1_gnt, v.g1);
    check1("mem_en", mem_en, v.men);
    check1("mmio_en", mmio_en, v.mmen);
    wa = v.g1 ? v.a1 : v.a0;
    wd = v.g1 ? v.d1 : v.d0;
    ww = v.g1 ? v.w1 : v.w0;
    if (v.men) begin
      check("mem_addr", mem_addr, wa);
      check1("mem_we", mem_we, ww);
      if (ww) check("mem_wdata", mem_wdata, wd);
    end else if (v.mmen) begin
      check("mmio_addr", mmio_addr, wa);
      check1("mmio_we", mmio_we, ww);
      if (ww) check("mmio_wdata", mmio_wdata, wd);
    end
    r.vld = v.g0 | v.g1; r.m1 = v.g1; r.rd = v.rd; r.err = v.err;
    sbq.push_back(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            pre r0 w0 l0 a0            d0     r1 w1 l1 a1            d1            g0 g1 me mm rd            err
    tbl[0]  = mk(1, 1, 0, 0, 32'h10,        0,     0, 0, 0, 0,            0,            1, 0, 1, 0, 32'hDEADBEEF, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0,             0,     0, 0, 0, 0,            0,            0, 0, 0, 0, 0,            0);
    tbl[2]  = mk(1, 1, 0, 0, 32'h10,        0,     1, 1, 0, 32'h04,       32'h11111111, 1, 0, 1, 0, 32'hDEADBEEF, 0);
    tbl[3]  = mk(0, 1, 0, 0, 32'h10,        0,     1, 1, 0, 32'h04,       32'h11111111, 0, 1, 1, 0, 0,            0);
    tbl[4]  = mk(0, 1, 0, 0, 32'h10,        0,     1, 1, 0, 32'h04,       32'h11111111, 1, 0, 1, 0, 32'hDEADBEEF, 0);
    tbl[5]  = mk(0, 1, 0, 0, 32'h10,        0,     1, 1, 0, 32'h04,       32'h11111111, 0, 1, 1, 0, 0,            0);
    tbl[6]  = mk(0, 1, 0, 0, 32'h10,        0,     0, 0, 0, 0,            0,            1, 0, 1, 0, 32'hDEADBEEF, 0);
    tbl[7]  = mk(0, 1, 0, 0, 32'h08,        0,     1, 1, 1, 32'h00,       32'd1,        0, 1, 1, 0, 0,            0);
    tbl[8]  = mk(0, 1, 0, 0, 32'h08,        0,     1, 1, 1, 32'h04,       32'd2,        0, 1, 1, 0, 0,            0);
    tbl[9]  = mk(0, 1, 0, 0, 32'h08,        0,     1, 1, 1, 32'h08,       32'd3,        0, 1, 1, 0, 0,            0);
    tbl[10] = mk(0, 1, 0, 0, 32'h08,        0,     0, 0, 0, 0,            0,            1, 0, 1, 0, 32'd3,        0);
    tbl[11] = mk(0, 1, 0, 0, 32'h04,        0,     0, 0, 0, 0,            0,            1, 0, 1, 0, 32'd2,        0);
    tbl[12] = mk(0, 1, 1, 0, 32'h0200000C,  32'd55, 0, 0, 0, 0,           0,            1, 0, 0, 1, 0,            0);
    tbl[13] = mk(0, 1, 0, 0, 32'h00001000,  0,     0, 0, 0, 0,            0,            1, 0, 0, 0, 0,            1);
    tbl[14] = mk(0, 0, 0, 0, 0,             0,     1, 0, 0, 32'h02000010, 0,            0, 1, 0, 1, 32'hA5A50010, 0);
    tbl[15] = mk(0, 1, 0, 0, 32'hFC,        0,     0, 0, 0, 0,            0,            1, 0, 1, 0, 32'h1000003F, 0);
    tbl[16] = mk(0, 1, 0, 0, 32'h100,       0,     0, 0, 0, 0,            0,            1, 0, 0, 0, 0,            1);
    tbl[17] = mk(0, 0, 0, 0, 0,             0,     1, 1, 0, 32'h02000100, 32'hCAFE,     0, 1, 0, 0, 0,            1);
    tbl[18] = mk(0, 0, 0, 0, 0,             0,     0, 0, 0, 0,            0,            0, 0, 0, 0, 0,            0);

    idle();
    reset = 1'b0;
    load  = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].pre_rst) do_reset();
      @(posedge clk); #1;
      check_resp();
      drive(tbl[i]);
      #2;
      check_issue(tbl[i]);
    end
    @(posedge clk); #1;
    check_resp();

    // Reset during a pending response: it must be dropped and rr_ptr must return to m0.
    drive(mk(0, 1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    check1("pre_rst_m0_gnt", m0_gnt, 1'b1);
    @(posedge clk);
    reset = 1'b0;
    idle();
    #1;
    check1("drop_m0_rvalid", m0_rvalid, 1'b0);
    check1("drop_busy", busy, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check1("held_m0_rvalid", m0_rvalid, 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check1("post_rst_m0_rvalid", m0_rvalid, 1'b0);
    drive(mk(0, 1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h14, 0, 0, 0, 0, 0, 0, 0));
    #2;
    check1("post_rst_rr_m0_gnt", m0_gnt, 1'b1);
    check1("post_rst_rr_m1_gnt", m1_gnt, 1'b0);
    @(posedge clk); #1;
    check1("post_rst_m0_rvalid", m0_rvalid, 1'b1);
    check("post_rst_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h14, 0, 0, 0, 0, 0, 0, 0));
    #2;
    check1("m1_only_gnt", m1_gnt, 1'b1);
    check1("m1_only_m0_gnt", m0_gnt, 1'b0);
    @(posedge clk); #1;
    idle();
    check1("m1_only_rvalid", m1_rvalid, 1'b1);
    check("m1_only_rdata", m1_rdata, 32'h1000_0005);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port and the MMIO window between two requesters: m0 = core load/store port, m1 = external loader/debug writer.
- Sits between the core data interface and the dmem / MMIO (LED, status) blocks.
- Provides round-robin arbitration with optional master lock, address decode, and 1-cycle response routing back to the owning master.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MMIO_BASE, 32'h0200_0000, base of the MMIO window.
- MMIO_MASK, 32'hFFFF_FF00, MMIO hit when (addr & MMIO_MASK) == MMIO_BASE.
- DMEM_WORDS, 64, dmem size in words; dmem window is byte addresses 0 .. 4*DMEM_WORDS-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- mN_req  in  1  request, N = 0, 1.
- mN_we  in  1  write enable.
- mN_lock  in  1  keep ownership after this grant.
- mN_be  in  DATA_W/8  byte enables.
- mN_addr  in  ADDR_W  byte address.
- mN_wdata  in  DATA_W  write data.
- mN_gnt  out  1  request accepted this cycle.
- mN_rvalid  out  1  response valid.
- mN_err  out  1  decode error, qualified by rvalid.
- mN_rdata  out  DATA_W  read data.
- mem_en / mem_we  out  1  dmem strobe / write.
- mem_be  out  DATA_W/8  dmem byte enables.
- mem_addr  out  ADDR_W  dmem address.
- mem_wdata  out  DATA_W  dmem write data.
- mem_rdata  in  DATA_W  dmem read data, valid the cycle after mem_en.
- mmio_en / mmio_we / mmio_be / mmio_addr / mmio_wdata  out  same widths as mem_*.
- mmio_rdata  in  DATA_W  valid the cycle after mmio_en.
- busy  out  1  response pending this cycle.

Behaviour:
- Reset (reset = 0, async): all outputs 0; rr_ptr = m0; lock_owner = none; pending response cleared. A pending response is dropped and never delivered.

Arbitration (combinational grant from registered state):
- If lock_owner is valid and that master requests, it wins.
- Otherwise, if only one master requests, it wins.
- If both request, the rr_ptr master wins.
- Exactly one mN_gnt is high per cycle, and only when its mN_req is high.

State updates on a grant:
- rr_ptr <= the loser.
- lock_owner <= winner if mN_lock, else none.
- Lock is also cleared when the owner deasserts req for one cycle.

Issue (same cycle as gnt), the winner's fields are routed by decode:
- MMIO hit: mmio_en = 1.
- Else, addr < 4*DMEM_WORDS: mem_en = 1.
- Else: decode error, no strobe.
- Both mem_addr and mmio_addr carry the full byte address.

Response:
- Exactly one cycle after gnt: mN_rvalid = 1 to the registered owner. Applies to writes too (ack) and to errors.
- rdata = mem_rdata or mmio_rdata for reads; 0 for writes and errors.
- err = 1 only on a decode error.
- busy = 1 in the response cycle.

Throughput and timing:
- Back-to-back grants allowed; one transaction per cycle.
- A response and a new grant may coincide.
- Read-after-write to the same address in consecutive cycles returns the new data, since dmem is written at the issue edge.
- rvalid is registered; no combinational path from mN_req to mN_rvalid.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- With it defined, three outputs are added: m0_gnt_cnt[15:0], m1_gnt_cnt[15:0] and conflict_cnt[15:0].
  - m0_gnt_cnt / m1_gnt_cnt increment on each grant to that master.
  - conflict_cnt increments on cycles where both masters request.
  - All three saturate at 16'hFFFF and reset to 0.
- Without it, these ports and counters do not exist; arbitration behaviour is identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - master-id enum (M0, M1, NONE);
  - target enum (TGT_DMEM, TGT_MMIO, TGT_ERR);
  - the default MMIO_BASE / MMIO_MASK constants.
- One natural sub-module: dmem_arb_decode, combinational address -> target enum.
- Arbiter, lock and response pipeline stay in dmem_arbiter.

Test Plan:
- m0 reads 0x10 alone (dmem holds 0xDEADBEEF) -> m0_gnt in cycle 0; m0_rvalid, rdata = 0xDEADBEEF in cycle 1; m1 outputs stay 0.
- Both masters request continuously, m1 writes 0x04 -> grants alternate m0, m1, m0, m1 starting with m0 after reset; each rvalid follows its gnt by 1 cycle.
- m1 asserts lock for 3 writes of 1, 2, 3 to 0x00/0x04/0x08 while m0 requests -> m1 granted 3 consecutive cycles, then m0 granted in cycle 3.
- m0 writes 55 to 0x0200000C -> mmio_en = 1, mmio_we = 1, mmio_wdata = 55; mem_en = 0; m0_rvalid next cycle with err = 0.
- m0 reads 0x0000_1000 -> no strobe; m0_rvalid = 1, m0_err = 1, rdata = 0 next cycle.
- Reset asserted in the cycle after a granted read -> no rvalid ever delivered; after release, rr_ptr = m0 and a fresh m1-only request is granted immediately.
